// File: rtl/bridge_pkg.sv
// Shared definitions for the Wishbone-to-AXI write bridge.
// Holds AXI burst/size/response encodings, the request-side FSM state
// encoding and a helper that derives AxSIZE from the data width.
package bridge_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StPulse,
    StWaitResp,
    StCooldown
  } wr_state_e;

  // log2 of the bus width in bytes; also the AxSIZE encoding for a full beat.
  function automatic logic [2:0] clog2_bytes(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/wb_to_axi_write_issuer_if.sv
// Bus bundle for the write issuer: Wishbone classic slave side plus the
// AXI AW and W channels.
// master: the issuer (accepts Wishbone, drives AW/W).
// slave:  the environment (drives Wishbone, accepts AW/W).
interface wb_to_axi_write_issuer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);

  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic                    wb_stall_o;

  logic [ID_WIDTH-1:0]     axi_awid;
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic [7:0]              axi_awlen;
  logic [2:0]              axi_awsize;
  logic [1:0]              axi_awburst;
  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_wlast;
  logic                    axi_wvalid;
  logic                    axi_wready;

  modport master (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_stall_o,
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready
  );

  modport slave (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_stall_o,
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready
  );

endinterface

// File: rtl/wb_to_axi_write_issuer_axi_valid_hold.sv
// Single-channel valid/ready hold register with a completion flag.
// load_i raises valid and clears done; valid stays high until the
// handshake, then drops on the next cycle and done is set.
// Ports: clk_i, rst_ni (sync, active-low), load_i, ready_i,
//        valid_o, done_o, fire_o (handshake this cycle).
module axi_valid_hold (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic ready_i,
  output logic valid_o,
  output logic done_o,
  output logic fire_o
);

  logic valid_d, valid_q;
  logic done_d, done_q;

  assign fire_o  = valid_q & ready_i;
  assign valid_o = valid_q;
  assign done_o  = done_q;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (load_i) begin
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else if (fire_o) begin
      valid_d = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/wb_to_axi_write_issuer.sv
// Request side of the Wishbone-to-AXI write bridge. Accepts one Wishbone
// classic write, issues a single-beat AXI write on AW and W, pulses
// resp_expected once both handshakes complete, then waits for the response
// handler's resp_received. A watchdog flags (but does not abort) a long wait.
// Ports: ACLK, ARESETN (sync, active-low), bus_io (Wishbone + AW/W),
//        resp_expected / resp_received (handler link), busy, wr_timeout.
module wb_to_axi_write_issuer
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  wb_to_axi_write_issuer_if.master        bus_io,
  output logic                            resp_expected,
  input  logic                            resp_received,
  output logic                            busy,
  output logic                            wr_timeout
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] Size = clog2_bytes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'((1 << Size) - 1);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES);

  wr_state_e             state_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;
  logic                  resp_expected_q;
  logic [WdogW-1:0]      wdog_q;

  logic accept;
  logic aw_valid, aw_done, aw_fire;
  logic w_valid, w_done, w_fire;
  logic both_done;

  assign accept = (state_q == StIdle) & bus_io.wb_cyc_i & bus_io.wb_stb_i & bus_io.wb_we_i;
  // Count handshakes happening this cycle so PULSE follows without a bubble.
  assign both_done = (aw_done | aw_fire) & (w_done | w_fire);

  axi_valid_hold u_aw_hold (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .load_i  (accept),
    .ready_i (bus_io.axi_awready),
    .valid_o (aw_valid),
    .done_o  (aw_done),
    .fire_o  (aw_fire)
  );

  axi_valid_hold u_w_hold (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .load_i  (accept),
    .ready_i (bus_io.axi_wready),
    .valid_o (w_valid),
    .done_o  (w_done),
    .fire_o  (w_fire)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q         <= StIdle;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      resp_expected_q <= 1'b0;
      wdog_q          <= '0;
    end else begin
      resp_expected_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            awaddr_q <= bus_io.wb_adr_i & AddrMask;
            wdata_q  <= bus_io.wb_dat_i;
            wstrb_q  <= bus_io.wb_sel_i;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (both_done) begin
            resp_expected_q <= 1'b1;
            state_q         <= StPulse;
          end
        end
        StPulse: state_q <= StWaitResp;
        StWaitResp: begin
          if (resp_received) begin
            wdog_q  <= '0;
            state_q <= StCooldown;
          end else if (wdog_q != WdogMax) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        // Gives the master a cycle to drop stb after the handler's ack.
        StCooldown: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.wb_stall_o  = (state_q != StIdle);
  assign busy               = (state_q != StIdle);
  assign resp_expected      = resp_expected_q;
  assign wr_timeout         = (wdog_q == WdogMax);

  assign bus_io.axi_awid    = ID_WIDTH'(AXI_ID);
  assign bus_io.axi_awaddr  = awaddr_q;
  assign bus_io.axi_awlen   = 8'd0;
  assign bus_io.axi_awsize  = Size;
  assign bus_io.axi_awburst = BURST_INCR;
  assign bus_io.axi_awvalid = aw_valid;
  assign bus_io.axi_wdata   = wdata_q;
  assign bus_io.axi_wstrb   = wstrb_q;
  assign bus_io.axi_wlast   = 1'b1;
  assign bus_io.axi_wvalid  = w_valid;

endmodule
